// File: rtl/timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_if
//
// Bundles the user-side signals of timer_ctrl: the single-cycle button pulses
// and the timer's ring flag going in, and the timer control/edit registers
// going out.
//
//   master : drives btn_* and ring, observes the control outputs
//            (debounce stage / testbench side)
//   slave  : timer_ctrl itself
//
// Signals
//   btn_mode, btn_inc, btn_dec, btn_start, btn_clear : single-cycle pulses
//   ring                                             : ring from count_down_timer
//   hour_bcd, minute_bcd, second_bcd [7:0]           : BCD edit registers
//   set_timer, reset_timer                           : one-cycle timer pulses
//   pause                                            : 1 freezes the timer
//   edit_field [1:0]                                 : 0 none, 1 h, 2 m, 3 s
//   buzzer                                           : alarm drive
// -----------------------------------------------------------------------------
interface timer_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_start;
  logic       btn_clear;
  logic       ring;

  logic [7:0] hour_bcd;
  logic [7:0] minute_bcd;
  logic [7:0] second_bcd;
  logic       set_timer;
  logic       reset_timer;
  logic       pause;
  logic [1:0] edit_field;
  logic       buzzer;

  modport master (
    output btn_mode, btn_inc, btn_dec, btn_start, btn_clear, ring,
    input  hour_bcd, minute_bcd, second_bcd,
    input  set_timer, reset_timer, pause, edit_field, buzzer
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, btn_start, btn_clear, ring,
    output hour_bcd, minute_bcd, second_bcd,
    output set_timer, reset_timer, pause, edit_field, buzzer
  );
endinterface

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//
// User-facing sequencer for count_down_timer. Turns button pulses into the
// timer's set_timer / reset_timer / pause controls, owns the BCD edit
// registers feeding the timer's *_bcd_in ports and runs the alarm phase.
//
// Parameters
//   MAX_HOUR    : largest editable hour, BCD (default 8'h23)
//   RING_CYCLES : cycles the buzzer stays on before the alarm ends (>= 1)
//
// Ports
//   clk   : timer clock, one cycle per countdown step
//   rst_n : asynchronous reset, active low
//   bus   : timer_ctrl_if.slave (buttons + ring in, controls + fields out)
//
// Every output is a register; a button pulse in cycle N is reflected in
// state and outputs in cycle N+1.
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter logic [7:0] MAX_HOUR    = 8'h23,
  parameter int         RING_CYCLES = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_ctrl_if.slave  bus
);

  localparam int CNT_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RING_CYCLES - 1);
  localparam logic [7:0] MAX_MINSEC = 8'h59;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    RUN    = 3'd4,
    PAUSED = 3'd5,
    ALARM  = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // BCD helpers: the digits are manipulated directly, no binary intermediate.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = top;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [7:0]       hour_q, hour_d;
  logic [7:0]       minute_q, minute_d;
  logic [7:0]       second_q, second_d;
  logic             set_timer_q, set_timer_d;
  logic             reset_timer_q, reset_timer_d;
  logic             pause_q, pause_d;
  logic             buzzer_q, buzzer_d;
  logic [1:0]       edit_field_q, edit_field_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;

  // ---------------------------------------------------------------------------
  // Button priority: clear > start > mode > inc > dec. Only the winner is seen
  // by the state logic; lower-priority pulses in the same cycle are dropped.
  // ---------------------------------------------------------------------------
  logic ev_clear, ev_start, ev_mode, ev_inc, ev_dec, any_btn;

  always_comb begin
    ev_clear = bus.btn_clear;
    ev_start = bus.btn_start & ~bus.btn_clear;
    ev_mode  = bus.btn_mode  & ~bus.btn_start & ~bus.btn_clear;
    ev_inc   = bus.btn_inc   & ~bus.btn_mode  & ~bus.btn_start & ~bus.btn_clear;
    ev_dec   = bus.btn_dec   & ~bus.btn_inc   & ~bus.btn_mode  & ~bus.btn_start
                             & ~bus.btn_clear;
    any_btn  = bus.btn_clear | bus.btn_start | bus.btn_mode | bus.btn_inc | bus.btn_dec;
  end

  logic fields_nonzero;
  assign fields_nonzero = (hour_q != 8'h00) || (minute_q != 8'h00) || (second_q != 8'h00);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    hour_d        = hour_q;
    minute_d      = minute_q;
    second_d      = second_q;
    set_timer_d   = 1'b0;
    reset_timer_d = 1'b0;
    ring_cnt_d    = ring_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (ev_clear) begin
          reset_timer_d = 1'b1;
        end else if (ev_start) begin
          // Starting a zero preset would ring immediately; ignore it.
          if (fields_nonzero) state_d = RUN;
        end else if (ev_mode) begin
          state_d = EDIT_H;
        end
      end

      EDIT_H, EDIT_M, EDIT_S: begin
        if (ev_clear) begin
          hour_d   = 8'h00;
          minute_d = 8'h00;
          second_d = 8'h00;
        end else if (ev_start) begin
          // start has no meaning while editing, and it still masks mode/inc/dec
        end else if (ev_mode) begin
          case (state_q)
            EDIT_H:  state_d = EDIT_M;
            EDIT_M:  state_d = EDIT_S;
            default: begin
              // Leaving the editor loads the preset; fields stay put afterwards.
              state_d     = IDLE;
              set_timer_d = 1'b1;
            end
          endcase
        end else if (ev_inc || ev_dec) begin
          case (state_q)
            EDIT_H:  hour_d   = ev_inc ? bcd_inc(hour_q,   MAX_HOUR)   : bcd_dec(hour_q,   MAX_HOUR);
            EDIT_M:  minute_d = ev_inc ? bcd_inc(minute_q, MAX_MINSEC) : bcd_dec(minute_q, MAX_MINSEC);
            default: second_d = ev_inc ? bcd_inc(second_q, MAX_MINSEC) : bcd_dec(second_q, MAX_MINSEC);
          endcase
        end
      end

      RUN: begin
        // start/clear beat ring arriving in the same cycle.
        if (ev_clear) begin
          state_d       = IDLE;
          reset_timer_d = 1'b1;
        end else if (ev_start) begin
          state_d = PAUSED;
        end else if (bus.ring) begin
          state_d    = ALARM;
          ring_cnt_d = '0;
        end
      end

      PAUSED: begin
        if (ev_clear) begin
          state_d       = IDLE;
          reset_timer_d = 1'b1;
        end else if (ev_start) begin
          state_d = RUN;
        end
      end

      ALARM: begin
        // The counter holds the index of the current buzzer cycle, so the
        // exit fires at the end of cycle RING_CYCLES.
        if (any_btn || (ring_cnt_q == CNT_LAST)) begin
          state_d       = IDLE;
          reset_timer_d = 1'b1;
        end else begin
          ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Level outputs are decoded from the next state so they are registered
    // alongside it and change in the same cycle as the state.
    pause_d  = (state_d != RUN);
    buzzer_d = (state_d == ALARM);
    case (state_d)
      EDIT_H:  edit_field_d = 2'd1;
      EDIT_M:  edit_field_d = 2'd2;
      EDIT_S:  edit_field_d = 2'd3;
      default: edit_field_d = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hour_q        <= 8'h00;
      minute_q      <= 8'h00;
      second_q      <= 8'h00;
      set_timer_q   <= 1'b0;
      reset_timer_q <= 1'b0;
      pause_q       <= 1'b1;
      buzzer_q      <= 1'b0;
      edit_field_q  <= 2'd0;
      ring_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      hour_q        <= hour_d;
      minute_q      <= minute_d;
      second_q      <= second_d;
      set_timer_q   <= set_timer_d;
      reset_timer_q <= reset_timer_d;
      pause_q       <= pause_d;
      buzzer_q      <= buzzer_d;
      edit_field_q  <= edit_field_d;
      ring_cnt_q    <= ring_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.hour_bcd    = hour_q;
  assign bus.minute_bcd  = minute_q;
  assign bus.second_bcd  = second_q;
  assign bus.set_timer   = set_timer_q;
  assign bus.reset_timer = reset_timer_q;
  assign bus.pause       = pause_q;
  assign bus.buzzer      = buzzer_q;
  assign bus.edit_field  = edit_field_q;

endmodule
